// File: rtl/dragon_if.sv
// Bundle of control, food-source, query and status signals around the dragon game core.
interface dragon_if #(
  parameter int COORD_W = 7,
  parameter int LEN_W   = 8,
  parameter int SCORE_W = 10
);
  logic               start, tick, up, down, left, right, wrap_en;
  logic [COORD_W-1:0] rnd_x, rnd_y, qx, qy;
  logic               body_hit, head_hit, food_hit;
  logic [COORD_W-1:0] head_x, head_y;
  logic [LEN_W-1:0]   length;
  logic [SCORE_W-1:0] score;
  logic               game_over, running;

  modport master (
    output start, tick, up, down, left, right, wrap_en, rnd_x, rnd_y, qx, qy,
    input  body_hit, head_hit, food_hit, head_x, head_y, length, score, game_over, running
  );
  modport slave (
    input  start, tick, up, down, left, right, wrap_en, rnd_x, rnd_y, qx, qy,
    output body_hit, head_hit, food_hit, head_x, head_y, length, score, game_over, running
  );
endinterface

// File: rtl/dragon_engine.sv
// Grid dragon game core: segment store, steering, growth, food placement,
// wall/wrap and self-collision, score, IDLE/RUN/OVER control, per-cell hit flags.
module dragon_engine #(
  parameter int GRID_W  = 80,
  parameter int GRID_H  = 60,
  parameter int COORD_W = 7,
  parameter int MAX_LEN = 128,
  parameter int LEN_W   = 8,
  parameter int GROW    = 4,
  parameter int SCORE_W = 10
)(
  input logic     pixel_clk,
  input logic     reset,
  dragon_if.slave bus
);
  localparam logic [COORD_W-1:0] PARK = '1;
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0] X0   = COORD_W'(GRID_W/2);
  localparam logic [COORD_W-1:0] Y0   = COORD_W'(GRID_H/2);
  localparam logic [COORD_W-1:0] FX   = COORD_W'(GRID_W/2 + GRID_W/4);
  localparam logic [COORD_W-1:0] XW1  = COORD_W'(GRID_W-1);
  localparam logic [COORD_W-1:0] XW2  = COORD_W'(GRID_W-2);
  localparam logic [COORD_W-1:0] YH1  = COORD_W'(GRID_H-1);
  localparam logic [COORD_W-1:0] YH2  = COORD_W'(GRID_H-2);
  localparam logic [LEN_W:0]     GROW_V = (LEN_W+1)'(GROW);
  localparam logic [LEN_W:0]     MAXL   = (LEN_W+1)'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t state, state_nx;
  dir_t   dir, pend, btn, dir_eff;
  logic [MAX_LEN-1:0][COORD_W-1:0] seg_x, seg_y;
  logic [LEN_W-1:0]   len;
  logic [SCORE_W-1:0] score;
  logic [COORD_W-1:0] food_x, food_y;
  logic               food_valid;
  logic               body_hit, head_hit, food_hit;

  logic [COORD_W-1:0] sx, sy, nx, ny;
  logic [MAX_LEN-1:0] active, self_cmp, q_cmp;
  logic [LEN_W:0]     len_grow;
  logic init, step, wall, fatal, eat, any_btn, rev, cand_ok;

  assign init     = reset || (!bus.start && state != IDLE);
  assign step     = (state == RUN) && bus.start && bus.tick;
  assign any_btn  = bus.up | bus.down | bus.left | bus.right;
  assign dir_eff  = step ? pend : dir;
  assign rev      = (len > LEN_W'(1)) && (btn == dir_t'(dir_eff ^ 2'b01));
  assign len_grow = {1'b0, len} + GROW_V;

  always_comb begin
    btn = D_RIGHT;
    if (bus.up)        btn = D_UP;
    else if (bus.down) btn = D_DOWN;
    else if (bus.left) btn = D_LEFT;
  end

  // Raw step first; wrap folds wall cells onto the opposite playfield edge.
  always_comb begin
    sx = seg_x[0];
    sy = seg_y[0];
    case (pend)
      D_UP:    sy = seg_y[0] - 1'b1;
      D_DOWN:  sy = seg_y[0] + 1'b1;
      D_LEFT:  sx = seg_x[0] - 1'b1;
      default: sx = seg_x[0] + 1'b1;
    endcase
    wall = (sx == '0) || (sx == XW1) || (sy == '0) || (sy == YH1);
    nx = sx;
    ny = sy;
    if (bus.wrap_en) begin
      if (sx == '0)       nx = XW2;
      else if (sx == XW1) nx = ONE;
      if (sy == '0)       ny = YH2;
      else if (sy == YH1) ny = ONE;
    end
  end

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    localparam logic [LEN_W:0] IP1 = (LEN_W+1)'(i + 1);
    localparam logic [LEN_W:0] IP2 = (LEN_W+1)'(i + 2);
    localparam bit             MID = (i >= 1);
    assign active[i]   = IP1 <= {1'b0, len};
    // The tail (index length-1) vacates on this move, so it is not a hazard.
    assign self_cmp[i] = MID && (IP2 <= {1'b0, len}) && seg_x[i] == nx && seg_y[i] == ny;
    assign q_cmp[i]    = active[i] && seg_x[i] == bus.qx && seg_y[i] == bus.qy;
  end

  assign fatal   = step && ((wall && !bus.wrap_en) || (|self_cmp));
  assign eat     = step && !fatal && food_valid && nx == food_x && ny == food_y;
  assign cand_ok = (bus.rnd_x >= ONE) && (bus.rnd_x <= XW2) &&
                   (bus.rnd_y >= ONE) && (bus.rnd_y <= YH2) &&
                   !(bus.rnd_x == seg_x[0] && bus.rnd_y == seg_y[0]);

  always_ff @(posedge pixel_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (!bus.start) state_nx = IDLE; else if (fatal) state_nx = OVER;
      OVER:    if (!bus.start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= PARK;
        seg_y[i] <= PARK;
      end
      seg_x[0]   <= X0;
      seg_y[0]   <= Y0;
      len        <= LEN_W'(1);
      score      <= '0;
      dir        <= D_RIGHT;
      pend       <= D_RIGHT;
      food_x     <= FX;
      food_y     <= Y0;
      food_valid <= 1'b1;
      body_hit   <= 1'b0;
      head_hit   <= 1'b0;
      food_hit   <= 1'b0;
    end else begin
      if (any_btn && !rev) pend <= btn;
      if (step) dir <= pend;
      if (step && !fatal) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          if (active[i]) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
        end
        seg_x[0] <= nx;
        seg_y[0] <= ny;
        if (eat) begin
          len        <= (len_grow > MAXL) ? MAXL[LEN_W-1:0] : len_grow[LEN_W-1:0];
          food_valid <= 1'b0;
          if (score != '1) score <= score + 1'b1;
        end
      end
      if (!food_valid && cand_ok) begin
        food_x     <= bus.rnd_x;
        food_y     <= bus.rnd_y;
        food_valid <= 1'b1;
      end
      body_hit <= |q_cmp;
      head_hit <= q_cmp[0];
      food_hit <= food_valid && food_x == bus.qx && food_y == bus.qy;
    end
  end

  assign bus.body_hit  = body_hit;
  assign bus.head_hit  = head_hit;
  assign bus.food_hit  = food_hit;
  assign bus.head_x    = seg_x[0];
  assign bus.head_y    = seg_y[0];
  assign bus.length    = len;
  assign bus.score     = score;
  assign bus.game_over = (state == OVER);
  assign bus.running   = (state == RUN);
endmodule

// File: doc/dragon_engine.md
Name: dragon_engine

Overview:
- Parametrised game core for the grid-based dragon game: head/body position store, direction control, growth, food placement, wall/wrap and self-collision detection, score, game-state FSM.
- Sits between the button debouncers / random-grid source and the VGA pixel path.
- Answers per-pixel cell queries with registered hit flags so the top level only muxes colours.
- New versus the fixed 80x60/128 game core: parametrised grid, length and growth; wrap-around mode; reversal blocking; score; food placement that rejects invalid coordinates.

Parameters:
- GRID_W, 80, grid width in cells; wall columns are x=0 and x=GRID_W-1.
- GRID_H, 60, grid height in cells; wall rows are y=0 and y=GRID_H-1.
- COORD_W, 7, coordinate width; 2^COORD_W-1 must be >= max(GRID_W,GRID_H) (park value).
- MAX_LEN, 128, number of segment registers.
- LEN_W, 8, length counter width; must hold MAX_LEN.
- GROW, 4, segments added per food eaten.
- SCORE_W, 10, score counter width.

Ports:
- pixel_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- start  in  1  level; 1 = play, 0 = return to idle.
- tick  in  1  one-cycle move strobe from the update-rate divider.
- up, down, left, right  in  1 each  debounced buttons.
- wrap_en  in  1  1 = outer edges wrap instead of killing; sampled at each tick.
- rnd_x  in  COORD_W  random x candidate for food.
- rnd_y  in  COORD_W  random y candidate for food.
- qx  in  COORD_W  query cell x (pixel xCount[9:3]).
- qy  in  COORD_W  query cell y.
- body_hit  out  1  registered: query cell holds any active segment.
- head_hit  out  1  registered: query cell is the head.
- food_hit  out  1  registered: query cell is the food.
- head_x  out  COORD_W  current head x.
- head_y  out  COORD_W  current head y.
- length  out  LEN_W  active segment count.
- score  out  SCORE_W  foods eaten; saturates at all-ones.
- game_over  out  1  high in the OVER state.
- running  out  1  high in the RUN state.

Behaviour:
- FSM states: IDLE, RUN, OVER.
  - IDLE -> RUN when start=1.
  - RUN -> OVER on a fatal tick.
  - OVER -> IDLE when start=0.
  - RUN -> IDLE when start=0.
- Entering IDLE (reset, or start=0 from any state) initialises:
  - seg[0] = (GRID_W/2, GRID_H/2); all other segments = (2^COORD_W-1, 2^COORD_W-1).
  - length=1, score=0, dir=RIGHT, pending_dir=RIGHT.
  - food=(GRID_W/2+GRID_W/4, GRID_H/2), food_valid=1.
  - all hit flags 0, game_over=0.
- Direction: each cycle, sample buttons with priority up>down>left>right into pending_dir.
  - Exact reversal of dir is ignored when length>1.
  - dir <= pending_dir on the tick, before the next head is computed.
- On tick in RUN, next head nh = seg[0] stepped one cell in the new dir.
  - With wrap_en=1, a step onto a wall cell wraps instead: x 0 <-> GRID_W-2 side handled as 1<->GRID_W-2 (playfield is 1..GRID_W-2, 1..GRID_H-2).
  - With wrap_en=0, nh on a wall cell is fatal.
  - nh equal to any active seg[i], 1<=i<=length-2, is fatal. The tail cell is excluded because it vacates this tick.
  - Fatal: positions frozen, state -> OVER next cycle.
  - Otherwise: seg[i] <= seg[i-1] for i<length (a growing body extends into parked slots), seg[0] <= nh.
  - If nh == food and food_valid: length <= min(length+GROW, MAX_LEN), score +1 (saturating), food_valid <= 0.
  - Growth appears over the following ticks: parked slots at index < new length take the shifted coordinates.
- Food placement: while food_valid=0, each cycle test (rnd_x, rnd_y).
  - Accept when 1<=rnd_x<=GRID_W-2, 1<=rnd_y<=GRID_H-2 and not equal to head: food <= candidate, food_valid <= 1.
  - Otherwise retry next cycle. While invalid, food_hit=0.
- Query path: one-cycle latency; flags reflect qx/qy of the previous cycle.
  - body_hit covers segments 0..length-1; parked segments never hit.
- Outputs in IDLE and OVER hold the last positions; the tick is ignored.
- reset has priority over every other input, including mid-tick.

Test Plan:
- Reset, start=1, 3 ticks with no button, wrap_en=0 -> head (40,30)->(43,30); length=1; score=0; running=1.
- Food at (60,30), 20 ticks right -> on 20th tick length=5, score=1. Drive rnd=(0,5) then (12,7) -> rnd (0,5) rejected; food=(12,7) two cycles after the eating tick.
- Head at (78,30) moving right: wrap_en=0, tick -> game_over=1 next cycle, head stays (78,30); wrap_en=1 -> head=(1,30), running=1.
- Moving right with length=5, press left -> direction unchanged; press up then left on separate ticks -> U-turn completes without collision.
- Length 5 turning down, left, up into its own body -> game_over on the tick hitting seg[3]. Tail-chasing square with length 4 -> no game_over.
- qx/qy sweep over (43,30) with head there -> head_hit=1 and body_hit=1 exactly one cycle later. Assert reset mid-RUN -> next cycle IDLE, length=1, game_over=0.
